// File: rtl/ycr_mprf_pkg.sv
// Shared constants and types for the multi-port integer register file.
package ycr_mprf_pkg;

    localparam int SP_IDX = 2;
    localparam int GP_IDX = 3;
    localparam int A0_IDX = 10;

    localparam int RD_ASYNC = 0;
    localparam int RD_SYNC  = 1;

    // Widest supported XLEN; narrower builds zero the upper data bits.
    localparam int MPRF_XLEN_MAX = 64;

    typedef struct packed {
        logic                     new_data;
        logic [MPRF_XLEN_MAX-1:0] data;
        logic                     parity;
    } mprf_byp_t;

endpackage

// File: rtl/ycr_mprf_wr_arb.sv
// Write-port arbiter: per-entry enable/data with higher-port priority, collision
// detection and per-read-port write-first bypass records.
module ycr_mprf_wr_arb
    import ycr_mprf_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 32,
    parameter int NR    = 2,
    parameter int NW    = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [NW-1:0]               wr_req,
    input  logic [NW*AW-1:0]            wr_addr,
    input  logic [NW*XLEN-1:0]          wr_data,
    input  logic [NR*AW-1:0]            rd_addr,
    output logic [DEPTH-1:0]            wr_en,
    output logic [DEPTH-1:0][XLEN-1:0]  wr_wdata,
    output logic                        wr_coll,
    output mprf_byp_t [NR-1:0]          rd_byp
);

    logic [NW-1:0] wr_vld;

    always_comb begin
        wr_vld   = '0;
        wr_en    = '0;
        wr_wdata = '0;
        wr_coll  = 1'b0;
        for (int p = 0; p < NW; p++) begin
            wr_vld[p] = wr_req[p] && (wr_addr[p*AW +: AW] != '0)
                        && (int'(wr_addr[p*AW +: AW]) < DEPTH);
            // later (higher-index) ports overwrite earlier ones
            if (wr_vld[p]) begin
                wr_en[wr_addr[p*AW +: AW]]    = 1'b1;
                wr_wdata[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
            end
        end
        for (int i = 0; i < NW; i++) begin
            for (int j = i + 1; j < NW; j++) begin
                if (wr_vld[i] && wr_vld[j] && (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW])) begin
                    wr_coll = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_byp = '0;
        for (int k = 0; k < NR; k++) begin
            if ((rd_addr[k*AW +: AW] != '0) && (int'(rd_addr[k*AW +: AW]) < DEPTH)
                && wr_en[rd_addr[k*AW +: AW]]) begin
                rd_byp[k].new_data         = 1'b1;
                rd_byp[k].data[XLEN-1:0]   = wr_wdata[rd_addr[k*AW +: AW]];
                rd_byp[k].parity           = ^wr_wdata[rd_addr[k*AW +: AW]];
            end
        end
    end

endmodule

// File: rtl/ycr_pipe_mprf_mp.sv
// Parametrised NR-read / NW-write integer register file with x0 hardwired to zero.
// Optional per-entry even parity is enabled by defining YCR_MPRF_PARITY_EN.
module ycr_pipe_mprf_mp
    import ycr_mprf_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter int NR     = 2,
    parameter int NW     = 2,
    parameter int RD_LAT = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NR-1:0]       rd_en_i,
    input  logic [NR*AW-1:0]    rd_addr_i,
    output logic [NR*XLEN-1:0]  rd_data_o,
    output logic [NR-1:0]       rd_perr_o,
    input  logic [NW-1:0]       wr_req_i,
    input  logic [NW*AW-1:0]    wr_addr_i,
    input  logic [NW*XLEN-1:0]  wr_data_i,
    output logic                wr_coll_o,
    output logic [XLEN-1:0]     stack_ptr_val,
    output logic [XLEN-1:0]     glbl_ptr_val,
    output logic [XLEN-1:0]     func_return_val
);

    if ((RD_LAT != RD_ASYNC) && (RD_LAT != RD_SYNC)) begin : g_bad_lat
        $error("ycr_pipe_mprf_mp: RD_LAT must be 0 or 1");
    end
    if (NW == 0) begin : g_bad_nw
        $error("ycr_pipe_mprf_mp: NW must be at least 1");
    end
    if (XLEN > MPRF_XLEN_MAX) begin : g_bad_xlen
        $error("ycr_pipe_mprf_mp: XLEN exceeds bypass record width");
    end

    logic [DEPTH-1:0]           wr_en;
    logic [DEPTH-1:0][XLEN-1:0] wr_wdata;
    logic                       wr_coll;
    mprf_byp_t [NR-1:0]         rd_byp;
    logic [XLEN-1:0]            regs [DEPTH];

    ycr_mprf_wr_arb #(
        .XLEN(XLEN), .DEPTH(DEPTH), .NR(NR), .NW(NW), .AW(AW)
    ) u_wr_arb (
        .wr_req   (wr_req_i),
        .wr_addr  (wr_addr_i),
        .wr_data  (wr_data_i),
        .rd_addr  (rd_addr_i),
        .wr_en    (wr_en),
        .wr_wdata (wr_wdata),
        .wr_coll  (wr_coll),
        .rd_byp   (rd_byp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++) regs[a] <= '0;
        end else begin
            for (int a = 1; a < DEPTH; a++) begin
                if (wr_en[a]) regs[a] <= wr_wdata[a];
            end
        end
    end

`ifdef YCR_MPRF_PARITY_EN
    logic [DEPTH-1:0] par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= '0;
        end else begin
            for (int a = 1; a < DEPTH; a++) begin
                if (wr_en[a]) par_q[a] <= ^wr_wdata[a];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_coll_o <= 1'b0;
        else        wr_coll_o <= wr_coll;
    end

    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          ra_ok;
        assign ra    = rd_addr_i[k*AW +: AW];
        assign ra_ok = (ra != '0) && (int'(ra) < DEPTH);

        if (RD_LAT == RD_ASYNC) begin : g_async
            assign rd_data_o[k*XLEN +: XLEN] = ra_ok ? regs[ra] : '0;
`ifdef YCR_MPRF_PARITY_EN
            assign rd_perr_o[k] = ra_ok && ((^regs[ra]) ^ par_q[ra]);
`else
            assign rd_perr_o[k] = 1'b0;
`endif
        end else begin : g_sync
            // Bypass record and array capture are kept apart so the array
            // read never passes through the write-data mux.
            mprf_byp_t       byp_q;
            logic [XLEN-1:0] arr_q;
`ifdef YCR_MPRF_PARITY_EN
            logic            arr_par_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)          arr_par_q <= 1'b0;
                else if (rd_en_i[k]) arr_par_q <= ra_ok && par_q[ra];
            end

            assign rd_perr_o[k] = byp_q.new_data ? ((^byp_q.data) ^ byp_q.parity)
                                                 : ((^arr_q) ^ arr_par_q);
`else
            assign rd_perr_o[k] = 1'b0;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    byp_q <= '0;
                    arr_q <= '0;
                end else if (rd_en_i[k]) begin
                    byp_q <= rd_byp[k];
                    arr_q <= ra_ok ? regs[ra] : '0;
                end
            end

            assign rd_data_o[k*XLEN +: XLEN] = byp_q.new_data ? byp_q.data[XLEN-1:0] : arr_q;
        end
    end

    if (DEPTH > SP_IDX) begin : g_sp
        assign stack_ptr_val = regs[SP_IDX];
    end else begin : g_no_sp
        assign stack_ptr_val = '0;
    end
    if (DEPTH > GP_IDX) begin : g_gp
        assign glbl_ptr_val = regs[GP_IDX];
    end else begin : g_no_gp
        assign glbl_ptr_val = '0;
    end
    if (DEPTH > A0_IDX) begin : g_a0
        assign func_return_val = regs[A0_IDX];
    end else begin : g_no_a0
        assign func_return_val = '0;
    end

endmodule

// File: tb/tb_ycr_pipe_mprf_mp.sv
// Directed bench for ycr_pipe_mprf_mp: registered-read instance plus an async-read
// instance sharing the same stimulus.
module tb_ycr_pipe_mprf_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk;
    logic            rst_n;
    logic [1:0]      rd_en_i;
    logic [2*AW-1:0] rd_addr_i;
    logic [1:0]      wr_req_i;
    logic [2*AW-1:0] wr_addr_i;
    logic [63:0]     wr_data_i;

    logic [63:0]     rd_data_o,  rd_data0;
    logic [1:0]      rd_perr_o,  rd_perr0;
    logic            wr_coll_o,  wr_coll0;
    logic [31:0]     sp_val, gp_val, a0_val, sp0, gp0, a00;

    ycr_pipe_mprf_mp #(.XLEN(32), .DEPTH(32), .NR(2), .NW(2), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_data_o), .rd_perr_o(rd_perr_o), .wr_req_i(wr_req_i),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_coll_o(wr_coll_o),
        .stack_ptr_val(sp_val), .glbl_ptr_val(gp_val), .func_return_val(a0_val)
    );

    ycr_pipe_mprf_mp #(.XLEN(32), .DEPTH(32), .NR(2), .NW(2), .RD_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_data0), .rd_perr_o(rd_perr0), .wr_req_i(wr_req_i),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_coll_o(wr_coll0),
        .stack_ptr_val(sp0), .glbl_ptr_val(gp0), .func_return_val(a00)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  req;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [1:0]  ren;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        ecoll;
    } vec_t;

    vec_t vecs [16];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        wr_req_i  = v.req;
        wr_addr_i = {v.wa1, v.wa0};
        wr_data_i = {v.wd1, v.wd0};
        rd_en_i   = v.ren;
        rd_addr_i = {v.ra1, v.ra0};
    endtask

    task automatic idle();
        wr_req_i  = 2'b00;
        wr_addr_i = '0;
        wr_data_i = '0;
        rd_en_i   = 2'b00;
        rd_addr_i = '0;
    endtask

`ifdef YCR_MPRF_PARITY_EN
    logic [31:0] par_flip;
`endif

    initial begin
        //            req    wa0   wd0           wa1   wd1           ren    ra0   ra1   e0            e1            coll
        vecs[0]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b11, 5'd5, 5'd5, 32'h0,        32'h0,        1'b0};
        vecs[1]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,        2'b11, 5'd1, 5'd1, 32'h0,        32'h0,        1'b0};
        vecs[2]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b11, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{2'b11, 5'd7, 32'h11,       5'd7, 32'h22,       2'b11, 5'd7, 5'd5, 32'h22,       32'hDEADBEEF, 1'b1};
        vecs[4]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b11, 5'd7, 5'd7, 32'h22,       32'h22,       1'b0};
        vecs[5]  = '{2'b10, 5'd0, 32'h0,        5'd9, 32'hA5A5A5A5, 2'b11, 5'd9, 5'd9, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
        vecs[6]  = '{2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 2'b11, 5'd0, 5'd9, 32'h0,        32'hA5A5A5A5, 1'b0};
        vecs[7]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b11, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0};
        vecs[8]  = '{2'b11, 5'd4, 32'h44,       5'd6, 32'h66,       2'b11, 5'd4, 5'd6, 32'h44,       32'h66,       1'b0};
        vecs[9]  = '{2'b01, 5'd4, 32'h1234,     5'd0, 32'h0,        2'b00, 5'd4, 5'd6, 32'h44,       32'h66,       1'b0};
        vecs[10] = '{2'b11, 5'd3, 32'h33,       5'd4, 32'h5678,     2'b00, 5'd4, 5'd6, 32'h44,       32'h66,       1'b0};
        vecs[11] = '{2'b01, 5'd4, 32'hAAAA,     5'd0, 32'h0,        2'b00, 5'd4, 5'd6, 32'h44,       32'h66,       1'b0};
        vecs[12] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        2'b01, 5'd4, 5'd2, 32'hAAAA,     32'h66,       1'b0};
        vecs[13] = '{2'b11, 5'd2, 32'h200,      5'd3, 32'h300,      2'b11, 5'd10,5'd2, 32'h0,        32'h200,      1'b0};
        vecs[14] = '{2'b01, 5'd10,32'hA0,       5'd0, 32'h0,        2'b10, 5'd10,5'd3, 32'h0,        32'h300,      1'b0};
        vecs[15] = '{2'b01, 5'd7, 32'h77,       5'd7, 32'h99,       2'b11, 5'd7, 5'd7, 32'h77,       32'h77,       1'b0};

        rst_n = 1'b0;
        idle();
        #12;
        chk("reset_rd_data", rd_data_o, 64'h0);
        chk("reset_perr", {62'h0, rd_perr_o}, 64'h0);
        chk("reset_coll", {63'h0, wr_coll_o}, 64'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i]);
            tick();
            chk($sformatf("vec%0d_rd0", i), {32'h0, rd_data_o[31:0]},  {32'h0, vecs[i].e0});
            chk($sformatf("vec%0d_rd1", i), {32'h0, rd_data_o[63:32]}, {32'h0, vecs[i].e1});
            chk($sformatf("vec%0d_coll", i), {63'h0, wr_coll_o}, {63'h0, vecs[i].ecoll});
            chk($sformatf("vec%0d_perr", i), {62'h0, rd_perr_o}, 64'h0);
        end

        idle();
        tick();
        chk("tap_sp", {32'h0, sp_val}, 64'h200);
        chk("tap_gp", {32'h0, gp_val}, 64'h300);
        chk("tap_a0", {32'h0, a0_val}, 64'hA0);
        chk("tap_a0_async_inst", {32'h0, a00}, 64'hA0);
        chk("coll_after_idle", {63'h0, wr_coll_o}, 64'h0);

        // async-read instance returns the pre-write value during a same-cycle write
        wr_req_i  = 2'b01;
        wr_addr_i = {5'd0, 5'd9};
        wr_data_i = {32'h0, 32'h5A5A5A5A};
        rd_addr_i = {5'd0, 5'd9};
        #1;
        chk("async_old_value", {32'h0, rd_data0[31:0]}, 64'hA5A5A5A5);
        chk("async_x0", {32'h0, rd_data0[63:32]}, 64'h0);
        tick();
        chk("async_new_value", {32'h0, rd_data0[31:0]}, 64'h5A5A5A5A);
        chk("async_perr", {62'h0, rd_perr0}, 64'h0);

        // parity: store x12 then read it back with its parity bit corrupted
        idle();
        wr_req_i  = 2'b01;
        wr_addr_i = {5'd0, 5'd12};
        wr_data_i = {32'h0, 32'h00000F0F};
        tick();
        idle();
`ifdef YCR_MPRF_PARITY_EN
        par_flip = dut.par_q ^ 32'h0000_1000;
        force dut.par_q = par_flip;
`endif
        rd_en_i   = 2'b11;
        rd_addr_i = {5'd12, 5'd12};
        tick();
        chk("par_rd_data", {32'h0, rd_data_o[31:0]}, 64'hF0F);
`ifdef YCR_MPRF_PARITY_EN
        chk("par_perr_flagged", {62'h0, rd_perr_o}, 64'h3);
        release dut.par_q;
`else
        chk("par_perr_tied_off", {62'h0, rd_perr_o}, 64'h0);
`endif

        // async reset mid-burst clears everything without a clock edge
        wr_req_i  = 2'b11;
        wr_addr_i = {5'd7, 5'd7};
        wr_data_i = {32'h1, 32'h2};
        rd_addr_i = {5'd5, 5'd12};
        tick();
        chk("pre_reset_coll", {63'h0, wr_coll_o}, 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_rd_data", rd_data_o, 64'h0);
        chk("rst_async_coll", {63'h0, wr_coll_o}, 64'h0);
        chk("rst_async_taps", {sp_val, a0_val}, 64'h0);
        chk("rst_async_inst0_rd", rd_data0, 64'h0);
        #3;
        rst_n = 1'b1;
        idle();
        rd_en_i   = 2'b11;
        rd_addr_i = {5'd5, 5'd7};
        tick();
        chk("post_reset_reads", rd_data_o, 64'h0);
        chk("post_reset_coll", {63'h0, wr_coll_o}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
